// File: rtl/alu_div_pkg.sv
// rtl/alu_div_pkg.sv - shared state encoding and default width for the sequential divider
package alu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 16;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor through a ripple-carry chain, restore on borrow
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] a;
  logic [WIDTH:0] b;
  logic [WIDTH:0] t;
  logic [WIDTH:0] c;

  assign a    = {r, q_msb};
  assign b    = ~{1'b0, d};
  assign c[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign t[i] = a[i] ^ b[i] ^ c[i];
    if (i < WIDTH) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  // The kept remainder is always below the divisor, so its top bit is zero
  // and only WIDTH bits need to be returned.
  assign q_bit  = ~t[WIDTH];
  assign r_next = q_bit ? t[WIDTH-1:0] : a[WIDTH-1:0];

endmodule

// File: rtl/seq_divider_16.sv
// rtl/seq_divider_16.sv - multi-cycle unsigned DIV/MOD unit, one quotient bit per clock
module seq_divider_16
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] r_step;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q_msb  (q_reg[WIDTH-1]),
    .d      (d_reg),
    .r_next (r_step),
    .q_bit  (q_bit)
  );

  assign q_next = {q_reg[WIDTH-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      done_valid  <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      d_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            d_reg       <= divisor;
            q_reg       <= dividend;
            r_reg       <= '0;
            count       <= '0;
            div_by_zero <= (divisor == '0);
            start_ready <= 1'b0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          r_reg <= r_step;
          q_reg <= q_next;
          count <= count + CNT_W'(1);
          // Results are captured from the final step directly, so they are
          // valid on the same edge that raises done_valid.
          if (count == CNT_W'(WIDTH - 1)) begin
            quotient   <= q_next;
            remainder  <= r_step;
            done_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid  <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          done_valid  <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16.sv
// tb/tb_seq_divider_16.sv - scoreboard bench for seq_divider_16 against a/b, a%b
module tb_seq_divider_16;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        done_valid;
  logic        done_ready = 1'b1;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   ready_mode = 0;
  bit   prev_dv = 1'b0;
  bit   ready_chk = 1'b0;
  exp_t exp_q[$];

  seq_divider_16 dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 16'd0) begin
      e.q = 16'hFFFF;
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Caller is always in the posedge+1 phase.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b);
    int t = 0;
    while (!start_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!start_ready) begin
      check("start_ready_timeout", 32'd0, 32'd1);
      return;
    end
    dividend    = a;
    divisor     = b;
    start_valid = 1'b1;
    accept_cyc  = cyc + 1;
    exp_q.push_back(model(a, b));
    @(posedge clk); #1;
    start_valid = 1'b0;
    dividend    = 16'($urandom);
    divisor     = 16'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || done_valid) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0 || done_valid) check("drain_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'($urandom_range(1, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: done_ready = 1'b1;
        1: done_ready = ($urandom_range(0, 3) != 0);
        default: done_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency, post-handshake idle, and scoreboard compare.
  always @(negedge clk) begin
    if (!rst) begin
      if (ready_chk) begin
        check("start_ready_after_done", {31'd0, start_ready}, 32'd1);
        check("done_valid_after_done", {31'd0, done_valid}, 32'd0);
        ready_chk = 1'b0;
      end
      if (done_valid && !prev_dv) check("latency", cyc - accept_cyc, 32'd16);
      prev_dv = done_valid;
      if (done_valid && done_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("quotient", {16'd0, quotient}, {16'd0, e.q});
          check("remainder", {16'd0, remainder}, {16'd0, e.r});
          check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        end
        ready_chk = 1'b1;
      end
    end
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_start_ready", {31'd0, start_ready}, 32'd1);
    check("rst_done_valid", {31'd0, done_valid}, 32'd0);
    check("rst_quotient", {16'd0, quotient}, 32'd0);
    check("rst_remainder", {16'd0, remainder}, 32'd0);
    check("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;

    ready_mode = 0;
    do_op(16'd100, 16'd7);       drain();
    do_op(16'hFFFF, 16'h0001);   drain();
    do_op(16'd5, 16'd9);         drain();
    do_op(16'h8000, 16'h8000);   drain();
    do_op(16'h1234, 16'h0000);   drain();
    do_op(16'd10, 16'd3);        drain();

    // Backpressure with spurious start pulses during BUSY and DONE.
    ready_mode = 2;
    @(posedge clk); #1;
    do_op(16'd1000, 16'd33);
    dividend = 16'd7; divisor = 16'd1; start_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    start_valid = 1'b0;
    t = 0;
    while (!done_valid && t < 100) begin @(posedge clk); #1; t++; end
    check("bp_done_seen", {31'd0, done_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      start_valid = (i == 2);
      @(negedge clk);
      check("bp_done_valid", {31'd0, done_valid}, 32'd1);
      check("bp_quotient", {16'd0, quotient}, 32'd30);
      check("bp_remainder", {16'd0, remainder}, 32'd10);
      @(posedge clk); #1;
    end
    start_valid = 1'b0;
    ready_mode = 0;
    drain();

    // Reset in the middle of an operation discards it.
    do_op(16'd50000, 16'd123);
    repeat (8) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_start_ready", {31'd0, start_ready}, 32'd1);
    check("midrst_done_valid", {31'd0, done_valid}, 32'd0);
    check("midrst_quotient", {16'd0, quotient}, 32'd0);
    check("midrst_remainder", {16'd0, remainder}, 32'd0);
    check("midrst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    do_op(16'd50000, 16'd123);
    drain();

    ready_mode = 1;
    for (int i = 0; i < 1000; i++) do_op(pick_operand(), pick_operand());
    ready_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/seq_divider_16.md
Name: seq_divider_16

Overview:
- Iterative unsigned restoring divider; the inverse-direction arithmetic companion to the team's combinational adder/subtractor in the ALU.
- Takes a dividend/divisor pair over a valid/ready handshake and produces quotient and remainder after WIDTH iteration cycles.
- Each iteration is one shift-and-subtract step: a (WIDTH+1)-bit two's-complement subtraction with restore on negative result.
- Sits beside the adder/subtractor in the ALU datapath as the multi-cycle DIV/MOD functional unit.

Parameters:
- WIDTH, 16, operand/result bit width (must be >= 2)
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start_valid  input  1  operand pair presented
- start_ready  output  1  unit idle and able to accept
- dividend  input  WIDTH  unsigned dividend, sampled on accept
- divisor  input  WIDTH  unsigned divisor, sampled on accept
- done_valid  output  1  result held stable
- done_ready  input  1  consumer accepts result
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  divisor was zero for this result

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: state=IDLE. start_ready=1, done_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
  - rst wins over every other event, including mid-BUSY and mid-DONE.
  - An in-flight operation is discarded; no result is produced for it.
- States: IDLE, BUSY, DONE. start_ready=1 only in IDLE. done_valid=1 only in DONE.
- IDLE: on an edge with start_valid=1, go to BUSY and latch:
  - divisor register (D) <- divisor
  - quotient/shift register Q <- dividend
  - partial remainder R <- 0 (WIDTH+1 bits)
  - counter <- 0
  - div_by_zero <- (divisor==0)
- BUSY, each edge:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D}, computed WIDTH+1 bits wide.
  - If T[WIDTH]==0 then R<=T and Q<={Q[WIDTH-2:0],1}; else R<={R[WIDTH-1:0],Q[WIDTH-1]} and Q<={Q[WIDTH-2:0],0}.
  - counter increments. When counter==WIDTH-1 on this edge, go to DONE.
- Output timing:
  - quotient and remainder outputs load from Q and R[WIDTH-1:0] on the edge that enters DONE.
  - done_valid is therefore first seen high exactly WIDTH edges after the accept edge.
- DONE: outputs hold stable while done_ready=0 (no time limit). On an edge with done_ready=1, go to IDLE; outputs keep their last values.
- Throughput: minimum WIDTH+2 cycles per operation. start_valid is ignored outside IDLE; no queuing.
- Divide by zero: there is no special datapath. The algorithm naturally yields quotient = all ones (0xFFFF) and remainder = dividend, with div_by_zero=1. Latency is unchanged.
- Operand inputs are don't-care except on the accept edge.
- Arithmetic: unsigned only. R never exceeds D after a step, so WIDTH+1 bits are sufficient with no overflow.

Decomposition:
- Shared package alu_div_pkg:
  - state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - default WIDTH constant
- One sub-module, div_step: purely combinational single iteration.
  - Inputs: R, Q MSB, D.
  - Outputs: next R, quotient bit.
  - Built on the ripple-carry full-adder subtract structure, with B inverted and carry-in=1.

Test Plan:
- 100/7, done_ready=1: accept at edge 0 -> done_valid high after edge 16; quotient=14, remainder=2, div_by_zero=0; start_ready high again the next cycle.
- 0xFFFF/0x0001 -> quotient=0xFFFF, remainder=0. Then 5/9 -> quotient=0, remainder=5. Then 0x8000/0x8000 -> quotient=1, remainder=0.
- 0x1234/0 -> quotient=0xFFFF, remainder=0x1234, div_by_zero=1, same 16-cycle latency. The next 10/3 must show div_by_zero=0.
- Backpressure on 1000/33: hold done_ready=0 for 5 cycles -> quotient=30, remainder=10 stable, done_valid stays 1. start_valid pulsed during BUSY/DONE is ignored. Release -> IDLE one edge later.
- Assert rst at BUSY iteration 8 of 50000/123 -> next cycle: IDLE, all outputs 0, start_ready=1. A fresh 50000/123 then gives quotient=406, remainder=62.
- Random-operand scoreboard (>=1000 pairs, including 0 and 0xFFFF) against the reference model a/b, a%b (divide-by-zero handled per rule above), with random done_ready stalls.
